// File: rtl/sorter_pkg.sv
// Shared types and constants for the BRAM bubble sorter.
package sorter_pkg;

  localparam int unsigned CycleCntWidth = 32;

  typedef enum logic [2:0] {
    StIdle,
    StRdA,
    StRdB,
    StCmp,
    StWrA,
    StWrB,
    StFin
  } state_e;

endpackage

// File: rtl/bram_sorter.sv
// In-place ascending bubble sort of BRAM words 0..N-1 over a single registered-address port.
// Optional busy-cycle counter enabled with BRAM_SORTER_CYCLE_CNT_EN.
module bram_sorter
  import sorter_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned N          = 1024
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic [ADDR_WIDTH-1:0]    mem_addr,
  output logic [DATA_WIDTH-1:0]    mem_din,
  output logic                     mem_we,
  input  logic [DATA_WIDTH-1:0]    mem_dout,
  output logic [CycleCntWidth-1:0] cycle_cnt
);

  localparam logic [ADDR_WIDTH-1:0] AddrOne = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] LimInit = ADDR_WIDTH'(N - 1);

  state_e                  state_q;
  logic [ADDR_WIDTH-1:0]   i_q, lim_q;
  logic [DATA_WIDTH-1:0]   a_q;
  logic                    swapped_q;

  logic last_cmp, swp_eff, pass_end;

  assign last_cmp = (i_q == lim_q - AddrOne);
  // The swap performed in WR_A/WR_B counts toward the current pass.
  assign swp_eff  = swapped_q | (state_q == StWrB);
  assign pass_end = ((state_q == StCmp) && (a_q <= mem_dout)) || (state_q == StWrB);

  // Outputs are registered for the state being entered, so they are valid throughout it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      busy      <= 1'b0;
      done      <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_din   <= '0;
      i_q       <= '0;
      lim_q     <= '0;
      swapped_q <= 1'b0;
      a_q       <= '0;
    end else begin
      mem_we <= 1'b0;
      done   <= 1'b0;
      case (state_q)
        StIdle: begin
          if (start) begin
            i_q       <= '0;
            lim_q     <= LimInit;
            swapped_q <= 1'b0;
            if (N == 1) begin
              state_q <= StFin;
              done    <= 1'b1;
            end else begin
              state_q  <= StRdA;
              busy     <= 1'b1;
              mem_addr <= '0;
            end
          end
        end
        StRdA: begin
          state_q  <= StRdB;
          mem_addr <= i_q + AddrOne;
        end
        StRdB: begin
          a_q     <= mem_dout;
          state_q <= StCmp;
        end
        StCmp: begin
          if (a_q > mem_dout) begin
            state_q  <= StWrA;
            mem_addr <= i_q;
            mem_din  <= mem_dout;
            mem_we   <= 1'b1;
          end
        end
        StWrA: begin
          swapped_q <= 1'b1;
          state_q   <= StWrB;
          mem_addr  <= i_q + AddrOne;
          mem_din   <= a_q;
          mem_we    <= 1'b1;
        end
        StWrB: ;
        StFin:   state_q <= StIdle;
        default: state_q <= StIdle;
      endcase

      if (pass_end) begin
        if (!last_cmp) begin
          i_q      <= i_q + AddrOne;
          state_q  <= StRdA;
          mem_addr <= i_q + AddrOne;
        end else if (!swp_eff || (lim_q == AddrOne)) begin
          state_q <= StFin;
          busy    <= 1'b0;
          done    <= 1'b1;
        end else begin
          lim_q     <= lim_q - AddrOne;
          i_q       <= '0;
          swapped_q <= 1'b0;
          state_q   <= StRdA;
          mem_addr  <= '0;
        end
      end
    end
  end

`ifdef BRAM_SORTER_CYCLE_CNT_EN
  logic [CycleCntWidth-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if ((state_q == StIdle) && start) begin
      cnt_q <= '0;
    end else if (busy) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign cycle_cnt = cnt_q;
`else
  assign cycle_cnt = '0;
`endif

endmodule

// File: tb/tb_bram_sorter.sv
// Directed self-checking bench for bram_sorter: three instances (N=4, N=8, N=1) with BRAM models.
module tb_bram_sorter;

`ifdef BRAM_SORTER_CYCLE_CNT_EN
  localparam bit CntEn = 1'b1;
`else
  localparam bit CntEn = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // N=4 instance
  logic        rst4, start4, busy4, done4, we4, ld4, clr4;
  logic [3:0]  addr4, ld_a4;
  logic [31:0] din4, dout4, ld_d4, cc4;
  logic [31:0] mem4 [16];
  logic [31:0] img4 [4];
  int          wrc4, bc4, dc4;

  // N=8 instance
  logic        rst8, start8, busy8, done8, we8, ld8, clr8;
  logic [3:0]  addr8, ld_a8;
  logic [31:0] din8, dout8, ld_d8, cc8;
  logic [31:0] mem8 [16];
  logic [31:0] img8 [8];
  int          wrc8, bc8, dc8;

  // N=1 instance
  logic        rst1, start1, busy1, done1, we1, clr1, seen1;
  logic [3:0]  addr1;
  logic [31:0] din1, cc1;
  logic [31:0] dout1 = 32'h0;

  bram_sorter #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .N(4)) dut4 (
    .clk(clk), .rst(rst4), .start(start4), .busy(busy4), .done(done4), .mem_addr(addr4),
    .mem_din(din4), .mem_we(we4), .mem_dout(dout4), .cycle_cnt(cc4)
  );
  bram_sorter #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .N(8)) dut8 (
    .clk(clk), .rst(rst8), .start(start8), .busy(busy8), .done(done8), .mem_addr(addr8),
    .mem_din(din8), .mem_we(we8), .mem_dout(dout8), .cycle_cnt(cc8)
  );
  bram_sorter #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .N(1)) dut1 (
    .clk(clk), .rst(rst1), .start(start1), .busy(busy1), .done(done1), .mem_addr(addr1),
    .mem_din(din1), .mem_we(we1), .mem_dout(dout1), .cycle_cnt(cc1)
  );

  // Read-first BRAMs with a bench load port, plus activity counters.
  always @(posedge clk) begin
    if (we4) mem4[addr4] <= din4;
    else if (ld4) mem4[ld_a4] <= ld_d4;
    dout4 <= mem4[addr4];
    if (we8) mem8[addr8] <= din8;
    else if (ld8) mem8[ld_a8] <= ld_d8;
    dout8 <= mem8[addr8];
  end

  always @(posedge clk) begin
    if (clr4) begin
      wrc4 <= 0; bc4 <= 0; dc4 <= 0;
    end else begin
      if (we4) wrc4 <= wrc4 + 1;
      if (busy4) bc4 <= bc4 + 1;
      if (done4) dc4 <= dc4 + 1;
    end
    if (clr8) begin
      wrc8 <= 0; bc8 <= 0; dc8 <= 0;
    end else begin
      if (we8) wrc8 <= wrc8 + 1;
      if (busy8) bc8 <= bc8 + 1;
      if (done8) dc8 <= dc8 + 1;
    end
    if (clr1) seen1 <= 1'b0;
    else if (busy1 || we1 || (addr1 != 4'd0)) seen1 <= 1'b1;
  end

  task automatic load4();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); ld4 = 1'b1; ld_a4 = k[3:0]; ld_d4 = img4[k];
    end
    @(negedge clk); ld4 = 1'b0;
  endtask

  task automatic load8();
    for (int k = 0; k < 8; k++) begin
      @(negedge clk); ld8 = 1'b1; ld_a8 = k[3:0]; ld_d8 = img8[k];
    end
    @(negedge clk); ld8 = 1'b0;
  endtask

  task automatic run4();
    bit seen = 1'b0;
    @(negedge clk); start4 = 1'b1; clr4 = 1'b1;
    @(negedge clk); start4 = 1'b0; clr4 = 1'b0;
    for (int k = 0; k < 400 && !seen; k++) begin
      @(negedge clk);
      if (done4) seen = 1'b1;
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL run4_timeout: done not seen, required within 400 cycles"); end
    repeat (2) @(negedge clk);
  endtask

  task automatic run8();
    bit seen = 1'b0;
    @(negedge clk); start8 = 1'b1; clr8 = 1'b1;
    @(negedge clk); start8 = 1'b0; clr8 = 1'b0;
    for (int k = 0; k < 800 && !seen; k++) begin
      @(negedge clk);
      if (done8) seen = 1'b1;
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL run8_timeout: done not seen, required within 800 cycles"); end
    repeat (2) @(negedge clk);
  endtask

  task automatic check_mem4(input string name, input logic [31:0] e0, input logic [31:0] e1,
                            input logic [31:0] e2, input logic [31:0] e3);
    logic [31:0] exp_v [4];
    exp_v = '{e0, e1, e2, e3};
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (mem4[k] !== exp_v[k]) begin
        errors++; $display("FAIL %s word%0d: got %h required %h", name, k, mem4[k], exp_v[k]);
      end
    end
  endtask

  task automatic test_reset();
    rst4 = 1'b1; rst8 = 1'b1; rst1 = 1'b1;
    start4 = 1'b0; start8 = 1'b0; start1 = 1'b0;
    ld4 = 1'b0; ld8 = 1'b0; ld_a4 = '0; ld_a8 = '0; ld_d4 = '0; ld_d8 = '0;
    clr4 = 1'b1; clr8 = 1'b1; clr1 = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (busy4 !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b required 0", busy4); end
    checks++; if (done4 !== 1'b0) begin errors++; $display("FAIL reset_done: got %b required 0", done4); end
    checks++; if (we4 !== 1'b0) begin errors++; $display("FAIL reset_we: got %b required 0", we4); end
    checks++; if (addr4 !== 4'd0) begin errors++; $display("FAIL reset_addr: got %h required 0", addr4); end
    checks++; if (din4 !== 32'd0) begin errors++; $display("FAIL reset_din: got %h required 0", din4); end
    checks++; if (cc4 !== 32'd0) begin errors++; $display("FAIL reset_cnt: got %0d required 0", cc4); end
    checks++; if (busy8 !== 1'b0) begin errors++; $display("FAIL reset_busy8: got %b required 0", busy8); end
    rst4 = 1'b0; rst8 = 1'b0; rst1 = 1'b0;
    clr4 = 1'b0; clr8 = 1'b0; clr1 = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_sort_small();
    img4 = '{32'd3, 32'd1, 32'd2, 32'd0};
    load4();
    run4();
    check_mem4("small", 32'd0, 32'd1, 32'd2, 32'd3);
    checks++; if (dc4 !== 1) begin errors++; $display("FAIL small_done_pulses: got %0d required 1", dc4); end
    checks++; if (busy4 !== 1'b0) begin errors++; $display("FAIL small_busy_after: got %b required 0", busy4); end
  endtask

  task automatic test_presorted();
    for (int k = 0; k < 8; k++) img8[k] = k;
    load8();
    run8();
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (mem8[k] !== k) begin errors++; $display("FAIL sorted word%0d: got %h required %h", k, mem8[k], k); end
    end
    checks++; if (wrc8 !== 0) begin errors++; $display("FAIL sorted_writes: got %0d required 0", wrc8); end
    checks++; if (bc8 !== 21) begin errors++; $display("FAIL sorted_busy_cycles: got %0d required 21", bc8); end
    checks++;
    if (cc8 !== (CntEn ? 32'd21 : 32'd0)) begin
      errors++; $display("FAIL sorted_cycle_cnt: got %0d required %0d", cc8, CntEn ? 21 : 0);
    end
  endtask

  task automatic test_reverse();
    img4 = '{32'd3, 32'd2, 32'd1, 32'd0};
    load4();
    run4();
    check_mem4("reverse", 32'd0, 32'd1, 32'd2, 32'd3);
    checks++; if (bc4 !== 30) begin errors++; $display("FAIL reverse_busy_cycles: got %0d required 30", bc4); end
    checks++; if (wrc4 !== 12) begin errors++; $display("FAIL reverse_writes: got %0d required 12", wrc4); end
    repeat (3) @(negedge clk);
    checks++;
    if (cc4 !== (CntEn ? 32'd30 : 32'd0)) begin
      errors++; $display("FAIL reverse_cycle_cnt: got %0d required %0d", cc4, CntEn ? 30 : 0);
    end
  endtask

  task automatic test_single();
    @(negedge clk); clr1 = 1'b1;
    @(negedge clk); clr1 = 1'b0; start1 = 1'b1;
    @(negedge clk); start1 = 1'b0;
    checks++; if (done1 !== 1'b1) begin errors++; $display("FAIL single_done: got %b required 1", done1); end
    @(negedge clk);
    checks++; if (done1 !== 1'b0) begin errors++; $display("FAIL single_done_width: got %b required 0", done1); end
    checks++; if (seen1 !== 1'b0) begin errors++; $display("FAIL single_no_access: got %b required 0", seen1); end
  endtask

  task automatic test_unsigned_dups();
    logic [31:0] exp_v [8];
    img8  = '{32'hFFFF_FFFF, 32'd5, 32'd0, 32'd5, 32'h8000_0000, 32'd7, 32'hFFFF_FFFF, 32'd1};
    exp_v = '{32'd0, 32'd1, 32'd5, 32'd5, 32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    load8();
    run8();
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (mem8[k] !== exp_v[k]) begin
        errors++; $display("FAIL unsigned word%0d: got %h required %h", k, mem8[k], exp_v[k]);
      end
    end
  endtask

  task automatic test_reset_mid_sort();
    bit hit = 1'b0;
    img4 = '{32'd3, 32'd2, 32'd1, 32'd0};
    load4();
    @(negedge clk); start4 = 1'b1;
    @(negedge clk); start4 = 1'b0;
    for (int k = 0; k < 50 && !hit; k++) begin
      if (we4) hit = 1'b1;
      else @(negedge clk);
    end
    checks++;
    if (!hit) begin errors++; $display("FAIL midrst_no_write: got no mem_we, required one within 50 cycles"); end
    rst4 = 1'b1;
    @(negedge clk);
    checks++; if (we4 !== 1'b0) begin errors++; $display("FAIL midrst_we: got %b required 0", we4); end
    checks++; if (busy4 !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b required 0", busy4); end
    // WR_A landed (word0 = 2) but WR_B did not (word1 still 2, not 3).
    check_mem4("midrst_image", 32'd2, 32'd2, 32'd1, 32'd0);
    rst4 = 1'b0;
    run4();
    check_mem4("midrst_resort", 32'd0, 32'd1, 32'd2, 32'd2);
  endtask

  initial begin
    test_reset();
    test_sort_small();
    test_presorted();
    test_reverse();
    test_single();
    test_unsigned_dups();
    test_reset_mid_sort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bram_sorter.md
BRAM_SORTER -- requirements
Module: bram_sorter

Interface
REQ-001 Parameter DATA_WIDTH, default 32: width of one BRAM word.
REQ-002 Parameter ADDR_WIDTH, default 10: BRAM address width.
REQ-003 Parameter N, default 1024: number of words to sort at addresses 0..N-1; legal range 1..2^ADDR_WIDTH.
REQ-004 clk  input  1  single clock; all state changes on posedge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 start  input  1  begin a sort; sampled only in IDLE.
REQ-007 busy  output  1  high while sorting (RD_A, RD_B, CMP, WR_A, WR_B).
REQ-008 done  output  1  one-cycle pulse when the sort completes.
REQ-009 mem_addr  output  ADDR_WIDTH  BRAM address; BRAM registers it, data valid on mem_dout the next cycle.
REQ-010 mem_din  output  DATA_WIDTH  BRAM write data.
REQ-011 mem_we  output  1  BRAM write enable.
REQ-012 mem_dout  input  DATA_WIDTH  BRAM read data.
REQ-013 cycle_cnt  output  32  busy-cycle count of the last or current sort.

Function
REQ-014 The block SHALL bubble-sort words 0..N-1 ascending, comparing as unsigned, with sole ownership of the BRAM port.
REQ-015 FSM states: IDLE, RD_A, RD_B, CMP, WR_A, WR_B, FIN.
REQ-016 IDLE: start=1 clears i=0, lim=N-1 and swapped=0, then goes to RD_A; if N==1, goes directly to FIN.
REQ-017 RD_A: mem_addr=i, goes to RD_B.
REQ-018 RD_B: latch a=mem_dout, set mem_addr=i+1, go to CMP.
REQ-019 CMP: latch b=mem_dout; if a>b, go to WR_A; otherwise apply the pass-end rule.
REQ-020 WR_A: mem_addr=i, mem_din=b, mem_we=1, set swapped=1, go to WR_B.
REQ-021 WR_B: mem_addr=i+1, mem_din=a, mem_we=1, then apply the pass-end rule.
REQ-022 Pass-end rule: if i<lim-1, then i=i+1 and go to RD_A.
REQ-023 Otherwise, if the pass had no swap (including the current compare) or lim==1, go to FIN.
REQ-024 Otherwise set lim=lim-1, i=0, swapped=0 and go to RD_A.
REQ-025 Cost per compare: 3 cycles without a swap, 5 cycles with a swap.
REQ-026 FIN: done=1 for exactly one cycle, then go to IDLE.
REQ-027 mem_we SHALL be 0 in every state except WR_A and WR_B.
REQ-028 start is ignored outside IDLE; start held high causes a new sort right after FIN.
REQ-029 Equal elements are never swapped.

Reset
REQ-030 rst SHALL force IDLE and set busy=0, done=0, mem_we=0, mem_addr=0, mem_din=0, cycle_cnt=0, i=0, lim=0, swapped=0.
REQ-031 rst mid-sort SHALL abort with no further writes in the cycle after rst is sampled; memory contents are left as-is.

Configuration
REQ-032 With macro BRAM_SORTER_CYCLE_CNT_EN defined, cycle_cnt clears when leaving IDLE on start, then increments each busy cycle and holds after FIN.
REQ-033 Without BRAM_SORTER_CYCLE_CNT_EN, cycle_cnt is tied to 0, the port is retained and no counter logic is built.

Structure
REQ-034 Package sorter_pkg holds the FSM state enum and the cycle_cnt width constant (32).
REQ-035 No sub-module; the BRAM is instantiated by the parent and wired to the mem_* ports.

Verification
REQ-036 N=4, memory {3,1,2,0}, pulse start -> memory {0,1,2,3}; done pulses once; busy low afterward.
REQ-037 N=8, memory already sorted 0..7 -> no mem_we; one pass; cycle_cnt=21.
REQ-038 N=4, memory {3,2,1,0} -> {0,1,2,3}; cycle_cnt=30 (passes of 15, 10 and 5 cycles); 12 write cycles.
REQ-039 N=1 -> done one cycle after start; busy never high; no BRAM access.
REQ-040 N=8, random unsigned data including duplicates and 0xFFFFFFFF -> output is a sorted permutation of the input.
REQ-041 rst asserted during WR_A -> mem_we=0 the next cycle; state IDLE; a following start sorts correctly.
